// File: rtl/pid_ctrl_param.sv
// ---------------------------------------------------------------------------
// pid_ctrl_param
//
// Parametrised PID controller for the pedal-assist motor loop. It turns the
// signed torque/cadence error into an unsigned drive magnitude for the
// commutation/PWM stage.
//
// A free-running counter raises a sample tick every 2^PER_W clocks. On the
// tick the error is latched, and a three-state FSM runs the compute:
//   IDLE -> ACC : integrator update, derivative difference, history shift
//   ACC  -> SUM : P + I + D, clamp to the output range, register drv_mag
//   SUM  -> IDLE
// drv_vld rises on the edge that ends SUM, two clocks after the edge that
// ends the tick cycle, together with the new drv_mag and saturation flags.
//
// Optional feature (compile-time macro PID_SLEW_LIMIT_EN):
//   when defined, each update moves drv_mag at most SLEW_MAX away from its
//   previous value, unless not_pedaling is high. sat_hi/sat_lo always
//   describe the clamp of the unlimited target.
//
// Ports:
//   clk           in   1      clock
//   rst_n         in   1      asynchronous, active-low reset
//   not_pedaling  in   1      holds integrator and error history at zero
//   error         in   ERR_W  signed error, latched on the sample tick
//   drv_mag       out  OUT_W  saturated drive magnitude, registered
//   drv_vld       out  1      one-clock pulse when drv_mag is updated
//   sat_hi        out  1      last update clamped to all ones
//   sat_lo        out  1      last update clamped to zero (negative sum)
// ---------------------------------------------------------------------------
module pid_ctrl_param #(
    parameter int ERR_W    = 13,
    parameter int OUT_W    = 12,
    parameter int INT_W    = 18,
    parameter int PER_W    = 20,
    parameter int KP_SH    = 0,
    parameter int KI_SH    = 5,
    parameter int KD_SH    = 2,
    parameter int D_HIST   = 3,
    parameter int D_SAT    = 255,
    parameter int SLEW_MAX = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    not_pedaling,
    input  logic signed [ERR_W-1:0] error,
    output logic [OUT_W-1:0]        drv_mag,
    output logic                    drv_vld,
    output logic                    sat_hi,
    output logic                    sat_lo
);

    localparam int SUM_W = ERR_W + 4;
    localparam int DIF_W = ERR_W + 1;
    localparam int OW1   = OUT_W + 1;

    localparam logic signed [INT_W-1:0] INT_MAX   = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [DIF_W-1:0] D_POS     = DIF_W'(D_SAT);
    localparam logic signed [DIF_W-1:0] D_NEG     = DIF_W'(-D_SAT);
    localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'((2 ** OUT_W) - 1);
    localparam logic [OUT_W:0]          SLEW_STEP = OW1'(SLEW_MAX);

`ifdef PID_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SUM  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PER_W-1:0]        cnt;
    logic                    tick;
    logic signed [ERR_W-1:0] e_q;
    logic signed [INT_W-1:0] integ;
    logic signed [ERR_W-1:0] hist [D_HIST];
    logic signed [DIF_W-1:0] d_sat;

    logic signed [INT_W:0]   integ_sum;
    logic signed [INT_W-1:0] integ_nxt;
    logic signed [DIF_W-1:0] d_diff;
    logic signed [DIF_W-1:0] d_clamp;

    logic signed [SUM_W-1:0] p_term;
    logic signed [SUM_W-1:0] i_term;
    logic signed [SUM_W-1:0] d_term;
    logic signed [SUM_W-1:0] sum;
    logic [OUT_W-1:0]        target;
    logic                    tgt_hi;
    logic                    tgt_lo;
    logic [OUT_W:0]          up_lim;
    logic [OUT_W-1:0]        mag_nxt;

    assign tick = &cnt;

    // Free-running sample counter; it simply wraps, so the tick is the
    // single all-ones count in every period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The compute takes two clocks and the tick period is
    // at least eight, so a tick is only ever seen while IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = ACC;
            ACC:     state_nxt = SUM;
            SUM:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the error on the tick so both compute stages work on one
    // consistent sample even if the input moves meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
        end else if (state == IDLE && tick) begin
            e_q <= error;
        end
    end

    // ACC-stage arithmetic. The integrator sum is one bit wider so both
    // the negative result and the positive overflow are visible; the
    // integrator is kept non-negative so the I term never pulls drive down.
    always_comb begin
        integ_sum = {integ[INT_W-1], integ}
                  + {{(INT_W+1-ERR_W){e_q[ERR_W-1]}}, e_q};
        if (integ_sum[INT_W]) begin
            integ_nxt = '0;
        end else if (integ_sum[INT_W-1]) begin
            integ_nxt = INT_MAX;
        end else begin
            integ_nxt = integ_sum[INT_W-1:0];
        end

        d_diff = {e_q[ERR_W-1], e_q}
               - {hist[D_HIST-1][ERR_W-1], hist[D_HIST-1]};
        if (d_diff > D_POS) begin
            d_clamp = D_POS;
        end else if (d_diff < D_NEG) begin
            d_clamp = D_NEG;
        end else begin
            d_clamp = d_diff;
        end
    end

    // Integrator, derivative register and error history. not_pedaling
    // wins over the ACC update so the loop restarts from a clean state
    // when the rider resumes; the derivative is still refreshed in ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ <= '0;
            d_sat <= '0;
            for (int i = 0; i < D_HIST; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (state == ACC) begin
                d_sat <= d_clamp;
            end
            if (not_pedaling) begin
                integ <= '0;
                for (int i = 0; i < D_HIST; i++) begin
                    hist[i] <= '0;
                end
            end else if (state == ACC) begin
                integ   <= integ_nxt;
                hist[0] <= e_q;
                for (int i = 1; i < D_HIST; i++) begin
                    hist[i] <= hist[i-1];
                end
            end
        end
    end

    // SUM-stage arithmetic: scale the three terms, add them, clamp to the
    // unsigned output range and optionally limit the step from the
    // previous drive value. The integrator is non-negative, so truncating
    // its shifted value to the sum width keeps the magnitude intact.
    always_comb begin
        p_term = {{(SUM_W-ERR_W){e_q[ERR_W-1]}}, e_q} <<< KP_SH;
        i_term = SUM_W'(integ >>> KI_SH);
        d_term = {{(SUM_W-DIF_W){d_sat[DIF_W-1]}}, d_sat} <<< KD_SH;
        sum    = p_term + i_term + d_term;

        target = sum[OUT_W-1:0];
        tgt_hi = 1'b0;
        tgt_lo = 1'b0;
        if (sum < 0) begin
            target = '0;
            tgt_lo = 1'b1;
        end else if (sum > OUT_MAX) begin
            target = '1;
            tgt_hi = 1'b1;
        end

        mag_nxt = target;
        up_lim  = {1'b0, drv_mag} + SLEW_STEP;
        if (SLEW_EN && !not_pedaling) begin
            if ({1'b0, target} > up_lim) begin
                mag_nxt = up_lim[OUT_W-1:0];
            end else if (({1'b0, target} + SLEW_STEP) < {1'b0, drv_mag}) begin
                mag_nxt = drv_mag - SLEW_STEP[OUT_W-1:0];
            end
        end
    end

    // Output register: drive magnitude and flags change only at the end of
    // SUM, and drv_vld marks exactly that update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_mag <= '0;
            drv_vld <= 1'b0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
        end else begin
            drv_vld <= (state == SUM);
            if (state == SUM) begin
                drv_mag <= mag_nxt;
                sat_hi  <= tgt_hi;
                sat_lo  <= tgt_lo;
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_pid_ctrl_param
//
// Directed self-checking bench for pid_ctrl_param with a 16-clock sample
// period (PER_W = 4). Reset is released one time unit after a rising edge,
// so the counter reaches all ones after edge 15, ACC runs after edge 16,
// SUM after edge 17 and drv_vld/drv_mag are seen after edge 18; every
// following update lands 16 edges later. Expected values are hand-computed
// from the controller equations (P = e, I = integ >>> 5, D = clamp(e -
// hist[2], +/-255) <<< 2).
// ---------------------------------------------------------------------------
module tb_pid_ctrl_param;

    localparam int ERR_W = 13;
    localparam int OUT_W = 12;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    not_pedaling;
    logic signed [ERR_W-1:0] error;
    logic [OUT_W-1:0]        drv_mag;
    logic                    drv_vld;
    logic                    sat_hi;
    logic                    sat_lo;

    int checks = 0;
    int errors = 0;

    pid_ctrl_param #(
        .PER_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .not_pedaling (not_pedaling),
        .error        (error),
        .drv_mag      (drv_mag),
        .drv_vld      (drv_vld),
        .sat_hi       (sat_hi),
        .sat_lo       (sat_lo)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic signed [ERR_W-1:0] err, input logic np);
        error        = err;
        not_pedaling = np;
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic stepClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset, check the reset state, release it one unit after an
    // edge and step to edge 2 so that the next update lies 16 edges ahead.
    task automatic resetDut(input string tag);
        rst_n = 1'b0;
        stepClk(2);
        checkOutput({tag, "_rst_mag"}, 32'(drv_mag), 32'd0);
        checkOutput({tag, "_rst_vld"}, 32'(drv_vld), 32'd0);
        checkOutput({tag, "_rst_hi"},  32'(sat_hi),  32'd0);
        checkOutput({tag, "_rst_lo"},  32'(sat_lo),  32'd0);
        rst_n = 1'b1;
        stepClk(2);
        checkOutput({tag, "_post_vld"}, 32'(drv_vld), 32'd0);
        checkOutput({tag, "_post_mag"}, 32'(drv_mag), 32'd0);
    endtask

    // Step pre edges (drv_vld must still be low), then one more edge on
    // which the update must appear.
    task automatic nextUpdate(input string tag, input int pre,
                              input logic [OUT_W-1:0] mag, input logic hi,
                              input logic lo);
        stepClk(pre);
        checkOutput({tag, "_vld_early"}, 32'(drv_vld), 32'd0);
        stepClk(1);
        checkOutput({tag, "_vld"}, 32'(drv_vld), 32'd1);
        checkOutput({tag, "_mag"}, 32'(drv_mag), 32'(mag));
        checkOutput({tag, "_hi"},  32'(sat_hi),  32'(hi));
        checkOutput({tag, "_lo"},  32'(sat_lo),  32'(lo));
    endtask

    initial begin
        logic vld_seen;

        rst_n = 1'b0;
        applyStimulus(13'sd0, 1'b0);

`ifdef PID_SLEW_LIMIT_EN
        $display("[TB] slew-limited step response");
        resetDut("slew");
        nextUpdate("slew_u1", 15, 12'd0, 1'b0, 1'b0);
        applyStimulus(13'sd1000, 1'b0);
        nextUpdate("slew_u2", 15, 12'd64,  1'b0, 1'b0);
        nextUpdate("slew_u3", 15, 12'd128, 1'b0, 1'b0);
        nextUpdate("slew_u4", 15, 12'd192, 1'b0, 1'b0);
        nextUpdate("slew_u5", 15, 12'd256, 1'b0, 1'b0);
`else
        $display("[TB] latency and constant error 100");
        applyStimulus(13'sd100, 1'b0);
        resetDut("e100");
        vld_seen = 1'b0;
        repeat (15) begin
            stepClk(1);
            vld_seen = vld_seen | drv_vld;
        end
        checkOutput("e100_no_vld_before_tick", 32'(vld_seen), 32'd0);
        checkOutput("e100_mag_before_tick", 32'(drv_mag), 32'd0);
        stepClk(1);
        checkOutput("e100_u1_vld", 32'(drv_vld), 32'd1);
        checkOutput("e100_u1_mag", 32'(drv_mag), 32'd503);
        stepClk(1);
        checkOutput("e100_u1_pulse_end", 32'(drv_vld), 32'd0);
        checkOutput("e100_u1_mag_hold", 32'(drv_mag), 32'd503);
        nextUpdate("e100_u2", 14, 12'd506, 1'b0, 1'b0);
        nextUpdate("e100_u3", 15, 12'd509, 1'b0, 1'b0);
        nextUpdate("e100_u4", 15, 12'd112, 1'b0, 1'b0);

        $display("[TB] derivative clamp with error 400");
        applyStimulus(13'sd400, 1'b0);
        resetDut("e400");
        nextUpdate("e400_u1", 15, 12'd1432, 1'b0, 1'b0);
        nextUpdate("e400_u2", 15, 12'd1445, 1'b0, 1'b0);
        nextUpdate("e400_u3", 15, 12'd1457, 1'b0, 1'b0);
        nextUpdate("e400_u4", 15, 12'd450,  1'b0, 1'b0);

        $display("[TB] negative error -200");
        applyStimulus(-13'sd200, 1'b0);
        resetDut("neg");
        nextUpdate("neg_u1", 15, 12'd0, 1'b0, 1'b1);
        nextUpdate("neg_u2", 15, 12'd0, 1'b0, 1'b1);
        nextUpdate("neg_u3", 15, 12'd0, 1'b0, 1'b1);
        nextUpdate("neg_u4", 15, 12'd0, 1'b0, 1'b1);
        checkOutput("neg_integ", 32'(dut.integ), 32'd0);

        $display("[TB] integrator saturation with error 4095");
        applyStimulus(13'sd4095, 1'b0);
        resetDut("sat");
        for (int i = 1; i <= 35; i++) begin
            nextUpdate($sformatf("sat_u%0d", i), 15, 12'hFFF, 1'b1, 1'b0);
            if (i == 32) checkOutput("sat_integ32", 32'(dut.integ), 32'd131040);
            if (i == 33) checkOutput("sat_integ33", 32'(dut.integ), 32'd131071);
        end
        checkOutput("sat_integ35", 32'(dut.integ), 32'd131071);

        $display("[TB] not_pedaling hold and release");
        applyStimulus(13'sd100, 1'b1);
        resetDut("np");
        nextUpdate("np_u1", 15, 12'd500, 1'b0, 1'b0);
        nextUpdate("np_u2", 15, 12'd500, 1'b0, 1'b0);
        checkOutput("np_integ_held", 32'(dut.integ), 32'd0);
        applyStimulus(13'sd100, 1'b0);
        nextUpdate("np_u3", 15, 12'd503, 1'b0, 1'b0);
        nextUpdate("np_u4", 15, 12'd506, 1'b0, 1'b0);

        $display("[TB] reset during compute");
        applyStimulus(13'sd100, 1'b0);
        resetDut("abort_a");
        stepClk(14);
        resetDut("abort_b");
        nextUpdate("abort_u1", 15, 12'd503, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
